fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register, and it decides each cycle whether the PC advances by 4, holds, or takes the redirect target computed by NPC for the D-stage instruction. It tolerates a slow instruction memory by latching a redirect that resolves while fetch is waiting. Branch delay-slot semantics are preserved in every case.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit freeze of F and D stages.
- imem_ready  in  1  instruction word for f_pc is valid this cycle.
- imem_instr  in  32  instruction word fetched at f_pc.
- d_npc_sel  in  3  NPC select of the D-stage instruction: 000 seq, 001 beq, 010 jal, 100 j, 011 jr.
- d_zero  in  1  beq compare result for the D-stage instruction.
- d_target  in  32  NPC output target for the D-stage instruction.
- f_pc  out  32  current fetch PC, drives instruction memory and NPC.
- f_pc4  out  32  f_pc + 4.
- d_valid  out  1  IF/ID register holds a real instruction.
- d_instr  out  32  IF/ID instruction; 0 (nop) when d_valid=0.
- d_pc  out  32  PC of the D-stage instruction.
- d_pc4  out  32  d_pc + 4.
- redirect  out  1  one-cycle pulse when a taken target is loaded into f_pc.
- pending  out  1  a resolved redirect is waiting for fetch to complete.
- misalign_err  out  1  sticky: some taken target had bits [1:0] != 0.
- redirect_cnt  out  CNT_W  saturating count of taken redirects.

## Operation
- taken = d_valid & (d_npc_sel ∈ {010, 100, 011} | (d_npc_sel == 001 & d_zero)). Any other select value is treated as sequential.
- tgt = {d_target[31:2], 2'b00}. If taken and d_target[1:0] != 0, set misalign_err. The redirect still proceeds to tgt.
- State machine, two states:
  - RUN: pending=0.
  - PEND: pending=1, pend_tgt register valid.
- Per-cycle priority when reset=0:
  1. stall=1: f_pc, the IF/ID register, the state and pend_tgt all hold. The D instruction is re-evaluated once stall drops.
  2. stall=0, imem_ready=0: f_pc holds. IF/ID loads a bubble (d_valid=0, d_instr=0; d_pc and d_pc4 hold). If taken, capture pend_tgt=tgt, go RUN→PEND, and raise misalign_err if applicable.
  3. stall=0, imem_ready=1: IF/ID loads {1, imem_instr, f_pc, f_pc4}. f_pc is then loaded as follows:
     - if taken, tgt; the state goes to RUN and any pend_tgt is discarded (a branch in a delay slot is undefined; D wins);
     - else if PEND, pend_tgt, and the state goes to RUN;
     - else f_pc+4.
- The delay slot is never flushed. The instruction at f_pc when a branch sits in D always enters D.
- redirect pulses in the cycle after f_pc is loaded from tgt or pend_tgt.
- redirect_cnt increments on each redirect pulse and saturates at all-ones.
- PC arithmetic is 32-bit modulo: f_pc=32'hFFFF_FFFC advances to 0.

## Timing
- Reset values: f_pc=RESET_PC, f_pc4=RESET_PC+4, d_valid=0, d_instr=0, d_pc=0, d_pc4=0, redirect=0, pending=0, misalign_err=0, redirect_cnt=0. State is RUN. Reset overrides every other input.
- f_pc4 and d_pc4 are combinational from their registers. All other outputs are registered.
- Redirect latency: the branch is in D at cycle n with stall=0 and imem_ready=1. The delay slot is in D at n+1, and f_pc=tgt at n+1.
- With a pending redirect, f_pc=pend_tgt takes effect the cycle after imem_ready first returns high with stall=0.
- Reset asserted while in PEND clears the pending redirect; no redirect occurs afterwards.

## Test plan
- Reset then free-run with imem_ready=1 and no branches: f_pc steps 0x3000, 0x3004, 0x3008. d_pc lags f_pc by one cycle. redirect=0.
- beq in D with d_zero=0, then the same case with d_zero=1 and d_target=0x3010: the zero=0 case yields sequential PC. The zero=1 case fetches the delay slot at 0x3008, then f_pc=0x3010, redirect pulses once and redirect_cnt=1.
- stall=1 for 3 cycles with a j (100) in D: f_pc and d_* stay frozen. The redirect to d_target happens only after stall drops.
- jal in D while imem_ready=0 for 2 cycles, d_target=0x3400: pending=1 and D shows bubbles. When imem_ready rises, the delay slot enters D, then f_pc=0x3400 and pending=0.
- jr (011) with d_target=0x3006: misalign_err=1 and stays set. f_pc=0x3004 after the delay slot.
- Force redirect_cnt near saturation with CNT_W=2 and take 5 redirects: the count stops at 3. Assert reset during PEND: all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC and the IF/ID register, and steers the PC between
// sequential, held and redirect targets while tolerating a slow instruction memory.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic [31:0]      imem_instr,
    input  logic [2:0]       d_npc_sel,
    input  logic             d_zero,
    input  logic [31:0]      d_target,
    output logic [31:0]      f_pc,
    output logic [31:0]      f_pc4,
    output logic             d_valid,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_pc4,
    output logic             redirect,
    output logic             pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        f_pc_q, f_pc_d;
    logic               d_valid_q, d_valid_d;
    logic [31:0]        d_instr_q, d_instr_d;
    logic [31:0]        d_pc_q, d_pc_d;
    logic [31:0]        d_pc4_q, d_pc4_d;
    logic [31:0]        pend_tgt_q, pend_tgt_d;
    logic               redirect_q, redirect_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               taken;
    logic               misaligned;
    logic [31:0]        tgt;
    logic [31:0]        f_pc_plus4;

    assign f_pc_plus4 = f_pc_q + 32'd4;
    assign tgt        = {d_target[31:2], 2'b00};
    assign misaligned = (d_target[1:0] != 2'b00);

    // Unlisted select encodings fall through as sequential.
    always_comb begin
        taken = 1'b0;
        if (d_valid_q) begin
            unique case (d_npc_sel)
                3'b010, 3'b100, 3'b011: taken = 1'b1;
                3'b001:                 taken = d_zero;
                default:                taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        d_valid_d  = d_valid_q;
        d_instr_d  = d_instr_q;
        d_pc_d     = d_pc_q;
        d_pc4_d    = d_pc4_q;
        pend_tgt_d = pend_tgt_q;
        redirect_d = 1'b0;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        if (!stall) begin
            if (taken && misaligned) begin
                misalign_d = 1'b1;
            end
            if (!imem_ready) begin
                // Fetch is still waiting: bubble into D and park any resolved redirect.
                d_valid_d = 1'b0;
                d_instr_d = 32'd0;
                if (taken) begin
                    pend_tgt_d = tgt;
                    state_d    = PEND;
                end
            end else begin
                d_valid_d = 1'b1;
                d_instr_d = imem_instr;
                d_pc_d    = f_pc_q;
                d_pc4_d   = f_pc_plus4;
                if (taken) begin
                    f_pc_d     = tgt;
                    state_d    = RUN;
                    redirect_d = 1'b1;
                end else if (state_q == PEND) begin
                    f_pc_d     = pend_tgt_q;
                    state_d    = RUN;
                    redirect_d = 1'b1;
                end else begin
                    f_pc_d = f_pc_plus4;
                end
            end
        end

        if (redirect_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            f_pc_q     <= RESET_PC;
            d_valid_q  <= 1'b0;
            d_instr_q  <= 32'd0;
            d_pc_q     <= 32'd0;
            d_pc4_q    <= 32'd0;
            pend_tgt_q <= 32'd0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            f_pc_q     <= f_pc_d;
            d_valid_q  <= d_valid_d;
            d_instr_q  <= d_instr_d;
            d_pc_q     <= d_pc_d;
            d_pc4_q    <= d_pc4_d;
            pend_tgt_q <= pend_tgt_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign f_pc         = f_pc_q;
    assign f_pc4        = f_pc_plus4;
    assign d_valid      = d_valid_q;
    assign d_instr      = d_instr_q;
    assign d_pc         = d_pc_q;
    assign d_pc4        = d_pc4_q;
    assign redirect     = redirect_q;
    assign pending      = (state_q == PEND);
    assign misalign_err = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a default instance plus a 2-bit counter instance
// driven by the same stimulus to exercise counter saturation.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_instr;
    logic [2:0]  d_npc_sel;
    logic        d_zero;
    logic [31:0] d_target;

    logic [31:0] f_pc, f_pc4, d_instr, d_pc, d_pc4;
    logic        d_valid, redirect, pending, misalign_err;
    logic [15:0] redirect_cnt;

    logic [31:0] s_f_pc, s_f_pc4, s_d_instr, s_d_pc, s_d_pc4;
    logic        s_d_valid, s_redirect, s_pending, s_misalign_err;
    logic [1:0]  s_redirect_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: the word encodes its own address.
    assign imem_instr = {16'hC0DE, f_pc[15:0]};

    fetch_ctrl u_dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .imem_instr(imem_instr), .d_npc_sel(d_npc_sel), .d_zero(d_zero), .d_target(d_target),
        .f_pc(f_pc), .f_pc4(f_pc4), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
        .d_pc4(d_pc4), .redirect(redirect), .pending(pending), .misalign_err(misalign_err),
        .redirect_cnt(redirect_cnt)
    );

    fetch_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .imem_instr(imem_instr), .d_npc_sel(d_npc_sel), .d_zero(d_zero), .d_target(d_target),
        .f_pc(s_f_pc), .f_pc4(s_f_pc4), .d_valid(s_d_valid), .d_instr(s_d_instr), .d_pc(s_d_pc),
        .d_pc4(s_d_pc4), .redirect(s_redirect), .pending(s_pending), .misalign_err(s_misalign_err),
        .redirect_cnt(s_redirect_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        d_npc_sel = 3'b000; d_zero = 1'b0; d_target = 32'd0;
        tick(); tick();
        checks++; if (f_pc !== 32'h3000) begin errors++; $display("FAIL reset_f_pc got %h want %h", f_pc, 32'h3000); end
        checks++; if (f_pc4 !== 32'h3004) begin errors++; $display("FAIL reset_f_pc4 got %h want %h", f_pc4, 32'h3004); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
        checks++; if (d_instr !== 32'd0) begin errors++; $display("FAIL reset_d_instr got %h want 0", d_instr); end
        checks++; if (d_pc !== 32'd0 || d_pc4 !== 32'd0) begin errors++; $display("FAIL reset_d_pc got %h/%h want 0/0", d_pc, d_pc4); end
        checks++; if (redirect !== 1'b0 || pending !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", redirect, pending, misalign_err); end
        checks++; if (redirect_cnt !== 16'd0 || s_redirect_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", redirect_cnt, s_redirect_cnt); end
        $display("reset: f_pc=%h d_valid=%b", f_pc, d_valid);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (f_pc !== 32'h3004 || d_pc !== 32'h3000 || d_valid !== 1'b1) begin errors++; $display("FAIL seq1 got f_pc=%h d_pc=%h v=%b want 3004 3000 1", f_pc, d_pc, d_valid); end
        checks++; if (d_instr !== 32'hC0DE3000 || d_pc4 !== 32'h3004) begin errors++; $display("FAIL seq1_instr got %h/%h want c0de3000/3004", d_instr, d_pc4); end
        tick();
        checks++; if (f_pc !== 32'h3008 || f_pc4 !== 32'h300C || d_pc !== 32'h3004 || redirect !== 1'b0) begin errors++; $display("FAIL seq2 got f_pc=%h f_pc4=%h d_pc=%h r=%b want 3008 300c 3004 0", f_pc, f_pc4, d_pc, redirect); end
        $display("sequential: f_pc=%h d_pc=%h", f_pc, d_pc);
    endtask

    task automatic test_beq();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        // beq at 0x3000 not taken
        d_npc_sel = 3'b001; d_zero = 1'b0; d_target = 32'h3010;
        tick();
        checks++; if (f_pc !== 32'h3008 || redirect !== 1'b0) begin errors++; $display("FAIL beq_nt got f_pc=%h r=%b want 3008 0", f_pc, redirect); end
        // beq at 0x3004 taken
        d_zero = 1'b1;
        tick();
        checks++; if (d_pc !== 32'h3008 || d_instr !== 32'hC0DE3008) begin errors++; $display("FAIL beq_slot got d_pc=%h instr=%h want 3008 c0de3008", d_pc, d_instr); end
        checks++; if (f_pc !== 32'h3010 || redirect !== 1'b1) begin errors++; $display("FAIL beq_t got f_pc=%h r=%b want 3010 1", f_pc, redirect); end
        d_npc_sel = 3'b000; d_zero = 1'b0;
        tick();
        checks++; if (redirect !== 1'b0 || redirect_cnt !== 16'd1 || d_pc !== 32'h3010 || f_pc !== 32'h3014) begin errors++; $display("FAIL beq_after got r=%b cnt=%0d d_pc=%h f_pc=%h want 0 1 3010 3014", redirect, redirect_cnt, d_pc, f_pc); end
        $display("beq: f_pc=%h cnt=%0d", f_pc, redirect_cnt);
    endtask

    task automatic test_stall();
        d_npc_sel = 3'b100; d_target = 32'h3100; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (f_pc !== 32'h3014 || d_pc !== 32'h3010 || d_valid !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL stall%0d got f_pc=%h d_pc=%h v=%b r=%b want 3014 3010 1 0", i, f_pc, d_pc, d_valid, redirect); end
        end
        stall = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h3100 || d_pc !== 32'h3014 || redirect !== 1'b1) begin errors++; $display("FAIL stall_j got f_pc=%h d_pc=%h r=%b want 3100 3014 1", f_pc, d_pc, redirect); end
        d_npc_sel = 3'b000;
        tick();
        checks++; if (f_pc !== 32'h3104 || d_pc !== 32'h3100 || redirect_cnt !== 16'd2) begin errors++; $display("FAIL stall_after got f_pc=%h d_pc=%h cnt=%0d want 3104 3100 2", f_pc, d_pc, redirect_cnt); end
        $display("stall: f_pc=%h cnt=%0d", f_pc, redirect_cnt);
    endtask

    task automatic test_pending();
        d_npc_sel = 3'b010; d_target = 32'h3400; imem_ready = 1'b0;
        tick();
        checks++; if (pending !== 1'b1 || d_valid !== 1'b0 || d_instr !== 32'd0 || d_pc !== 32'h3100 || f_pc !== 32'h3104) begin errors++; $display("FAIL pend1 got p=%b v=%b instr=%h d_pc=%h f_pc=%h want 1 0 0 3100 3104", pending, d_valid, d_instr, d_pc, f_pc); end
        d_npc_sel = 3'b000; d_target = 32'h0;
        tick();
        checks++; if (pending !== 1'b1 || d_valid !== 1'b0 || f_pc !== 32'h3104 || redirect !== 1'b0) begin errors++; $display("FAIL pend2 got p=%b v=%b f_pc=%h r=%b want 1 0 3104 0", pending, d_valid, f_pc, redirect); end
        imem_ready = 1'b1;
        tick();
        checks++; if (d_valid !== 1'b1 || d_pc !== 32'h3104 || f_pc !== 32'h3400 || pending !== 1'b0 || redirect !== 1'b1) begin errors++; $display("FAIL pend3 got v=%b d_pc=%h f_pc=%h p=%b r=%b want 1 3104 3400 0 1", d_valid, d_pc, f_pc, pending, redirect); end
        tick();
        checks++; if (d_pc !== 32'h3400 || f_pc !== 32'h3404 || redirect_cnt !== 16'd3) begin errors++; $display("FAIL pend4 got d_pc=%h f_pc=%h cnt=%0d want 3400 3404 3", d_pc, f_pc, redirect_cnt); end
        $display("pending: f_pc=%h cnt=%0d", f_pc, redirect_cnt);
    endtask

    task automatic test_misalign();
        d_npc_sel = 3'b011; d_target = 32'h3006;
        tick();
        checks++; if (misalign_err !== 1'b1 || f_pc !== 32'h3004 || d_pc !== 32'h3404) begin errors++; $display("FAIL misalign got m=%b f_pc=%h d_pc=%h want 1 3004 3404", misalign_err, f_pc, d_pc); end
        d_npc_sel = 3'b000; d_target = 32'h0;
        tick();
        checks++; if (misalign_err !== 1'b1 || f_pc !== 32'h3008) begin errors++; $display("FAIL misalign_sticky got m=%b f_pc=%h want 1 3008", misalign_err, f_pc); end
        $display("misalign: m=%b f_pc=%h", misalign_err, f_pc);
    endtask

    task automatic test_saturate();
        d_npc_sel = 3'b100; d_target = 32'h3200;
        tick();
        d_npc_sel = 3'b000;
        tick();
        checks++; if (s_redirect_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d want 3", s_redirect_cnt); end
        checks++; if (redirect_cnt !== 16'd5 || f_pc !== 32'h3204) begin errors++; $display("FAIL cnt5 got cnt=%0d f_pc=%h want 5 3204", redirect_cnt, f_pc); end
        $display("saturate: cnt=%0d sat_cnt=%0d", redirect_cnt, s_redirect_cnt);
    endtask

    task automatic test_wrap();
        d_npc_sel = 3'b100; d_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (f_pc !== 32'hFFFF_FFFC || f_pc4 !== 32'd0) begin errors++; $display("FAIL wrap1 got f_pc=%h f_pc4=%h want fffffffc 0", f_pc, f_pc4); end
        d_npc_sel = 3'b000; d_target = 32'h0;
        tick();
        checks++; if (f_pc !== 32'd0 || d_pc !== 32'hFFFF_FFFC || d_pc4 !== 32'd0) begin errors++; $display("FAIL wrap2 got f_pc=%h d_pc=%h d_pc4=%h want 0 fffffffc 0", f_pc, d_pc, d_pc4); end
        $display("wrap: f_pc=%h d_pc=%h", f_pc, d_pc);
    endtask

    task automatic test_reset_pending();
        d_npc_sel = 3'b010; d_target = 32'h3400; imem_ready = 1'b0;
        tick();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rp_pend got %b want 1", pending); end
        reset = 1'b1; d_npc_sel = 3'b000; d_target = 32'h0; imem_ready = 1'b1;
        tick();
        checks++; if (pending !== 1'b0 || f_pc !== 32'h3000 || d_valid !== 1'b0 || d_pc !== 32'd0 || misalign_err !== 1'b0 || redirect_cnt !== 16'd0) begin errors++; $display("FAIL rp_reset got p=%b f_pc=%h v=%b d_pc=%h m=%b cnt=%0d want 0 3000 0 0 0 0", pending, f_pc, d_valid, d_pc, misalign_err, redirect_cnt); end
        reset = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h3004 || redirect !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL rp_run1 got f_pc=%h r=%b p=%b want 3004 0 0", f_pc, redirect, pending); end
        tick();
        checks++; if (f_pc !== 32'h3008 || redirect !== 1'b0) begin errors++; $display("FAIL rp_run2 got f_pc=%h r=%b want 3008 0", f_pc, redirect); end
        $display("reset_pending: f_pc=%h p=%b", f_pc, pending);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_beq();
        test_stall();
        test_pending();
        test_misalign();
        test_saturate();
        test_wrap();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
